// File: rtl/pc_fetch_pkg.sv
// Shared types and helpers for the PC fetch sequencer.
package pc_fetch_pkg;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Next-PC source selection for pc_next_sel.
  typedef enum logic [1:0] {
    SEL_HOLD  = 2'd0,
    SEL_INC   = 2'd1,
    SEL_REDIR = 2'd2,
    SEL_PEND  = 2'd3
  } pc_sel_t;

  // Mask of the low address bits that must be zero for an INC-aligned PC.
  // INC is a power of two, so INC-1 is exactly those bits.
  function automatic logic [63:0] align_mask(input int unsigned inc);
    return 64'(inc) - 64'd1;
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC mux: sequential increment, aligned redirect target,
// pending target or hold. Also flags a misaligned redirect target.
module pc_next_sel
  import pc_fetch_pkg::*;
#(
  parameter int unsigned N   = 32,
  parameter int unsigned INC = 4
) (
  input  pc_sel_t        sel,
  input  logic [N-1:0]   pc,
  input  logic [N-1:0]   redirect_target,
  input  logic [N-1:0]   pend_target,
  output logic [N-1:0]   next_pc,
  output logic [N-1:0]   aligned_target,
  output logic           misalign
);

  localparam logic [N-1:0] MASK = N'(align_mask(INC));
  localparam logic [N-1:0] STEP = N'(INC);

  // Clear the low alignment bits and report whether any were set.
  always_comb begin
    aligned_target = redirect_target & ~MASK;
    misalign       = |(redirect_target & MASK);
  end

  // Select the next PC; the increment wraps modulo 2^N by construction.
  always_comb begin
    unique case (sel)
      SEL_INC:   next_pc = pc + STEP;
      SEL_REDIR: next_pc = aligned_target;
      SEL_PEND:  next_pc = pend_target;
      default:   next_pc = pc;
    endcase
  end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// CPU front-end fetch sequencer: one imem req/ack per instruction, then a
// valid/ready hand-off to decode. Execute redirects squash wrong-path work.
module pc_fetch_sequencer
  import pc_fetch_pkg::*;
#(
  parameter int unsigned  N        = 32,
  parameter logic [N-1:0] RESET_PC = '0,
  parameter int unsigned  INC      = 4
) (
  input  logic         clk,
  input  logic         rst,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_ack,
  input  logic [N-1:0] imem_rdata,
  input  logic         redirect_valid,
  input  logic [N-1:0] redirect_target,
  output logic         instr_valid,
  input  logic         instr_ready,
  output logic [N-1:0] instr,
  output logic [N-1:0] instr_pc,
  output logic         misalign_err
);

  state_t       state, state_n;
  pc_sel_t      sel;
  logic [N-1:0] pc, next_pc;
  logic [N-1:0] aligned_target;
  logic         misalign;
  logic         pend, pend_n;
  logic [N-1:0] pend_target, pend_target_n;
  logic         capture;

  pc_next_sel #(
    .N   (N),
    .INC (INC)
  ) u_next_sel (
    .sel             (sel),
    .pc              (pc),
    .redirect_target (redirect_target),
    .pend_target     (pend_target),
    .next_pc         (next_pc),
    .aligned_target  (aligned_target),
    .misalign        (misalign)
  );

  // The address is the PC register itself, so it cannot move while a
  // request is outstanding: the PC only changes on ack or outside REQ.
  assign imem_addr = pc;

  // Next-state, PC source and pending-redirect decisions.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a variable unassigned and a latch is never inferred.
    state_n       = state;
    sel           = SEL_HOLD;
    pend_n        = pend;
    pend_target_n = pend_target;
    capture       = 1'b0;
    unique case (state)
      IDLE: begin
        state_n = REQ;
        if (redirect_valid) sel = SEL_REDIR;
      end
      REQ: begin
        if (imem_ack) begin
          if (redirect_valid) begin
            // Wrong-path data: drop it and restart from the new target.
            sel     = SEL_REDIR;
            pend_n  = 1'b0;
            state_n = IDLE;
          end else if (pend) begin
            sel     = SEL_PEND;
            pend_n  = 1'b0;
            state_n = IDLE;
          end else begin
            sel     = SEL_INC;
            capture = 1'b1;
            state_n = OUT;
          end
        end else if (redirect_valid) begin
          // Memory still owns the request; remember the target, last wins.
          pend_n        = 1'b1;
          pend_target_n = aligned_target;
        end
      end
      OUT: begin
        // A redirect beats a same-cycle ready: the instruction is dropped.
        if (redirect_valid) begin
          sel     = SEL_REDIR;
          state_n = REQ;
        end else if (instr_ready) begin
          state_n = REQ;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, PC, pending redirect and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      pend         <= 1'b0;
      pend_target  <= '0;
      imem_req     <= 1'b0;
      instr_valid  <= 1'b0;
      instr        <= '0;
      instr_pc     <= '0;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_n;
      pc           <= next_pc;
      pend         <= pend_n;
      pend_target  <= pend_target_n;
      imem_req     <= (state_n == REQ);
      instr_valid  <= (state_n == OUT);
      misalign_err <= redirect_valid && misalign;
      if (capture) begin
        instr    <= imem_rdata;
        instr_pc <= pc;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer. Inputs change and outputs are
// sampled on the falling edge, half a cycle away from the active edge.
module tb_pc_fetch_sequencer;

  localparam int unsigned N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         imem_req;
  logic [N-1:0] imem_addr;
  logic         imem_ack;
  logic [N-1:0] imem_rdata;
  logic         redirect_valid;
  logic [N-1:0] redirect_target;
  logic         instr_valid;
  logic         instr_ready;
  logic [N-1:0] instr;
  logic [N-1:0] instr_pc;
  logic         misalign_err;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  pc_fetch_sequencer #(
    .N        (N),
    .RESET_PC (32'h0),
    .INC      (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .misalign_err    (misalign_err)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b0; imem_ack = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b0;
    imem_rdata = '0; redirect_target = '0;
    step(); step();
    rst = 1'b1;
    step(); // IDLE -> REQ
  endtask

  task automatic test_reset();
    rst = 1'b0; imem_ack = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b0;
    imem_rdata = '0; redirect_target = '0;
    step(); step();
    n_total++;
    if ({imem_req, instr_valid, misalign_err} !== 3'b000)
      $display("FAIL reset_flags: got %b want 000", {imem_req, instr_valid, misalign_err});
    else n_pass++;
    n_total++;
    if ({instr, instr_pc, imem_addr} !== 96'h0)
      $display("FAIL reset_data: got %h/%h/%h want 0/0/0", instr, instr_pc, imem_addr);
    else n_pass++;
    rst = 1'b1;
    step(); // first post-reset edge: IDLE -> REQ
    n_total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0)
      $display("FAIL reset_first_req: got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr);
    else n_pass++;
  endtask

  task automatic test_sequential();
    logic [N-1:0] data [3] = '{32'h11, 32'h22, 32'h33};
    logic [N-1:0] pcs  [3] = '{32'h0, 32'h4, 32'h8};
    instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (imem_req !== 1'b1 || imem_addr !== pcs[i] || instr_valid !== 1'b0)
        $display("FAIL seq_req%0d: got req=%b addr=%h valid=%b want 1/%h/0",
                 i, imem_req, imem_addr, instr_valid, pcs[i]);
      else n_pass++;
      imem_ack = 1'b1; imem_rdata = data[i];
      step();
      imem_ack = 1'b0;
      n_total++;
      if (instr_valid !== 1'b1 || instr !== data[i] || instr_pc !== pcs[i] || imem_req !== 1'b0)
        $display("FAIL seq_out%0d: got valid=%b instr=%h pc=%h req=%b want 1/%h/%h/0",
                 i, instr_valid, instr, instr_pc, imem_req, data[i], pcs[i]);
      else n_pass++;
      step();
    end
    n_total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hC)
      $display("FAIL seq_next: got req=%b addr=%h want 1/0000000c", imem_req, imem_addr);
    else n_pass++;
  endtask

  task automatic test_redirect_pending();
    apply_reset();
    instr_ready = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hAA;
    step();
    imem_ack = 1'b0;
    step(); // REQ at 0x4
    redirect_valid = 1'b1; redirect_target = 32'h100;
    step();
    redirect_valid = 1'b0;
    n_total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h4)
      $display("FAIL pend_hold1: got req=%b addr=%h want 1/00000004", imem_req, imem_addr);
    else n_pass++;
    step();
    n_total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h4)
      $display("FAIL pend_hold2: got req=%b addr=%h want 1/00000004", imem_req, imem_addr);
    else n_pass++;
    imem_ack = 1'b1; imem_rdata = 32'hBB;
    step();
    imem_ack = 1'b0;
    n_total++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'hAA)
      $display("FAIL pend_discard: got req=%b valid=%b instr=%h want 0/0/000000aa",
               imem_req, instr_valid, instr);
    else n_pass++;
    step();
    n_total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100)
      $display("FAIL pend_target: got req=%b addr=%h want 1/00000100", imem_req, imem_addr);
    else n_pass++;
  endtask

  task automatic test_stall_redirect();
    instr_ready = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hCC;
    step();
    imem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (instr_valid !== 1'b1 || instr !== 32'hCC || instr_pc !== 32'h100)
        $display("FAIL stall%0d: got valid=%b instr=%h pc=%h want 1/000000cc/00000100",
                 i, instr_valid, instr, instr_pc);
      else n_pass++;
      step();
    end
    redirect_valid = 1'b1; redirect_target = 32'h40; instr_ready = 1'b1;
    step();
    redirect_valid = 1'b0; instr_ready = 1'b0;
    n_total++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40)
      $display("FAIL redir_vs_ready: got valid=%b req=%b addr=%h want 0/1/00000040",
               instr_valid, imem_req, imem_addr);
    else n_pass++;
  endtask

  task automatic test_align_wrap();
    imem_ack = 1'b1; imem_rdata = 32'hDD;
    step(); // OUT
    imem_ack = 1'b0;
    redirect_valid = 1'b1; redirect_target = 32'h102;
    step();
    redirect_valid = 1'b0;
    n_total++;
    if (misalign_err !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'h100)
      $display("FAIL misalign: got err=%b req=%b addr=%h want 1/1/00000100",
               misalign_err, imem_req, imem_addr);
    else n_pass++;
    step();
    n_total++;
    if (misalign_err !== 1'b0)
      $display("FAIL misalign_pulse: got err=%b want 0", misalign_err);
    else n_pass++;
    imem_ack = 1'b1; imem_rdata = 32'hEE;
    step();
    imem_ack = 1'b0;
    n_total++;
    if (instr_valid !== 1'b1 || instr !== 32'hEE || instr_pc !== 32'h100)
      $display("FAIL aligned_fetch: got valid=%b instr=%h pc=%h want 1/000000ee/00000100",
               instr_valid, instr, instr_pc);
    else n_pass++;
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    n_total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC || misalign_err !== 1'b0)
      $display("FAIL top_fetch: got req=%b addr=%h err=%b want 1/fffffffc/0",
               imem_req, imem_addr, misalign_err);
    else n_pass++;
    imem_ack = 1'b1; imem_rdata = 32'hF0;
    step();
    imem_ack = 1'b0; instr_ready = 1'b1;
    n_total++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC || instr !== 32'hF0)
      $display("FAIL top_out: got valid=%b pc=%h instr=%h want 1/fffffffc/000000f0",
               instr_valid, instr_pc, instr);
    else n_pass++;
    step();
    n_total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0)
      $display("FAIL wrap: got req=%b addr=%h want 1/00000000", imem_req, imem_addr);
    else n_pass++;
  endtask

  task automatic test_reset_mid_fetch();
    imem_ack = 1'b1; imem_rdata = 32'h77;
    step(); // OUT, ready=1
    imem_ack = 1'b0;
    step(); // REQ at 0x4
    step(); // still waiting
    n_total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h4)
      $display("FAIL mid_wait: got req=%b addr=%h want 1/00000004", imem_req, imem_addr);
    else n_pass++;
    rst = 1'b0;
    step();
    n_total++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0 || imem_addr !== 32'h0)
      $display("FAIL mid_reset: got req=%b valid=%b instr=%h addr=%h want 0/0/0/0",
               imem_req, instr_valid, instr, imem_addr);
    else n_pass++;
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h99; // ack lands in IDLE
    step();
    imem_ack = 1'b0;
    n_total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0 || instr !== 32'h0)
      $display("FAIL idle_ack: got req=%b addr=%h valid=%b instr=%h want 1/0/0/0",
               imem_req, imem_addr, instr_valid, instr);
    else n_pass++;
    imem_ack = 1'b1; imem_rdata = 32'h55;
    step();
    imem_ack = 1'b0;
    n_total++;
    if (instr_valid !== 1'b1 || instr !== 32'h55 || instr_pc !== 32'h0)
      $display("FAIL post_reset_fetch: got valid=%b instr=%h pc=%h want 1/00000055/0",
               instr_valid, instr, instr_pc);
    else n_pass++;
  endtask

  initial begin
    step();
    test_reset();
    test_sequential();
    test_redirect_pending();
    test_stall_redirect();
    test_align_wrap();
    test_reset_mid_fetch();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
